// File: rtl/stackcalc_sequencer.sv
// Program sequencer for the stack calculator: buffers instruction nibbles, replays them on run.
// Optional trace outputs (trace_valid/trace_data) are enabled by defining STACKCALC_SEQ_TRACE_EN.
module stackcalc_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [3:0]        load_nibble,
    output logic              load_ready,
    input  logic              run,
    output logic [3:0]        calc_in,
    output logic              calc_step,
    input  logic [3:0]        calc_out,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len
`ifdef STACKCALC_SEQ_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [3:0]        trace_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W:0]   FULL_LEN    = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_nxt;
    logic [3:0]          prog_mem [DEPTH];
    logic [ADDR_W-1:0]   pc;
    logic [CNT_W-1:0]    settle_cnt;
    logic                full;
    logic                settle_done;
    logic                last_instr;
    logic                run_go;
    logic                load_go;

    assign full        = (prog_len == FULL_LEN);
    assign load_ready  = (state == S_IDLE) && !full && !run && !clear;
    assign load_go     = load_valid && load_ready;
    assign run_go      = (state == S_IDLE) && !clear && run && (prog_len != '0);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_instr  = ({1'b0, pc} == (prog_len - 1'b1));
    assign calc_step   = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (run_go) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (settle_done) state_nxt = last_instr ? S_CAPTURE : S_ISSUE;
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // calc_in is loaded on the edge that enters ISSUE so it is stable for the whole strobe cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len     <= '0;
            pc           <= '0;
            calc_in      <= '0;
            settle_cnt   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        prog_len     <= '0;
                        result_valid <= 1'b0;
                    end else if (run_go) begin
                        pc           <= '0;
                        result_valid <= 1'b0;
                        calc_in      <= prog_mem[0];
                    end else if (load_go) begin
                        prog_len <= prog_len + 1'b1;
                    end
                end
                S_ISSUE: begin
                    settle_cnt <= '0;
                end
                S_WAIT: begin
                    if (!settle_done) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else if (!last_instr) begin
                        pc      <= pc + 1'b1;
                        calc_in <= prog_mem[pc + 1'b1];
                    end
                end
                S_CAPTURE: begin
                    result       <= calc_out;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_go) begin
            prog_mem[prog_len[ADDR_W-1:0]] <= load_nibble;
        end
    end

`ifdef STACKCALC_SEQ_TRACE_EN
    always_comb begin
        trace_valid = (state == S_WAIT) && settle_done;
        trace_data  = trace_valid ? calc_out : '0;
    end
`endif

endmodule

// File: tb/tb_stackcalc_sequencer.sv
// Self-checking bench for stackcalc_sequencer: directed steps plus randomized programs
// checked against a timing/arithmetic reference model (bench acts as an adding calculator).
module tb_stackcalc_sequencer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int SETTLE = 1;
    localparam int PERIOD = 1 + SETTLE;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              load_valid;
    logic [3:0]        load_nibble;
    logic              load_ready;
    logic              run;
    logic [3:0]        calc_in;
    logic              calc_step;
    logic [3:0]        calc_out;
    logic [3:0]        result;
    logic              result_valid;
    logic              busy;
    logic [ADDR_W:0]   prog_len;
`ifdef STACKCALC_SEQ_TRACE_EN
    logic              trace_valid;
    logic [3:0]        trace_data;
    logic [3:0]        trace_q [$];
`endif

    stackcalc_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_nibble  (load_nibble),
        .load_ready   (load_ready),
        .run          (run),
        .calc_in      (calc_in),
        .calc_step    (calc_step),
        .calc_out     (calc_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .prog_len     (prog_len)
`ifdef STACKCALC_SEQ_TRACE_EN
        ,
        .trace_valid  (trace_valid),
        .trace_data   (trace_data)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Bench-side calculator: accumulates every stepped nibble, or drives a fixed override.
    logic       acc_clr = 1'b0;
    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = '0;
    logic [3:0] acc     = '0;
    assign calc_out = ovr_en ? ovr_val : acc;

    typedef struct {
        int         edge_no;
        logic [3:0] nib;
    } step_t;

    step_t      step_q [$];
    logic [3:0] prog_q [$];

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (calc_step === 1'b1) step_q.push_back('{edge_n, calc_in});
        if (acc_clr) acc <= '0;
        else if (calc_step === 1'b1) acc <= acc + calc_in;
`ifdef STACKCALC_SEQ_TRACE_EN
        if (trace_valid === 1'b1) trace_q.push_back(trace_data);
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_calc_in"}, calc_in, 0);
        chk({tag, "_calc_step"}, calc_step, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_prog_len"}, prog_len, 0);
        chk({tag, "_load_ready"}, load_ready, 1);
    endtask

    task automatic load_nib(input logic [3:0] n);
        bit ok;
        ok = (prog_q.size() < DEPTH);
        load_valid  = 1'b1;
        load_nibble = n;
        #1;
        chk("load_ready", load_ready, ok);
        @(negedge clk);
        load_valid = 1'b0;
        if (ok) prog_q.push_back(n);
        chk("prog_len", prog_len, prog_q.size());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        chk("clear_load_ready", load_ready, 0);
        @(negedge clk);
        clear = 1'b0;
        prog_q.delete();
        chk("clear_prog_len", prog_len, 0);
        chk("clear_result_valid", result_valid, 0);
    endtask

    task automatic run_program(input bit pulse);
        int         len;
        int         t;
        int         sum;
        logic [3:0] exp_res;
        len = prog_q.size();
        step_q.delete();
`ifdef STACKCALC_SEQ_TRACE_EN
        trace_q.delete();
`endif
        run     = 1'b1;
        acc_clr = 1'b1;
        t       = edge_n;
        @(negedge clk);
        run     = 1'b0;
        acc_clr = 1'b0;
        for (int i = 0; i <= len * PERIOD + 1; i++) begin
            int e;
            bit step_exp;
            e        = t + 1 + i;
            step_exp = 1'b0;
            for (int k = 0; k < len; k++) if (e == t + 1 + k * PERIOD) step_exp = 1'b1;
            chk("busy", busy, e <= t + 1 + len * PERIOD);
            chk("calc_step", calc_step, step_exp);
            chk("result_valid", result_valid, e >= t + 2 + len * PERIOD);
            if (pulse) begin
                run         = (i == 1);
                clear       = (i == 1);
                load_valid  = (i == 2);
                load_nibble = 4'hF;
            end
            @(negedge clk);
        end
        run        = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("step_count", step_q.size(), len);
        for (int k = 0; k < len && k < step_q.size(); k++) begin
            chk("step_edge", step_q[k].edge_no - t, 1 + k * PERIOD);
            chk("step_nib", step_q[k].nib, prog_q[k]);
        end
        sum = 0;
        for (int k = 0; k < len; k++) sum += prog_q[k];
        exp_res = ovr_en ? ovr_val : sum[3:0];
        chk("result", result, exp_res);
        chk("prog_len_kept", prog_len, len);
`ifdef STACKCALC_SEQ_TRACE_EN
        chk("trace_count", trace_q.size(), len);
        sum = 0;
        for (int k = 0; k < len && k < trace_q.size(); k++) begin
            sum += prog_q[k];
            chk("trace_data", trace_q[k], ovr_en ? ovr_val : sum[3:0]);
        end
`endif
    endtask

    initial begin
        int n0;
        int len;
        rst         = 1'b1;
        clear       = 1'b0;
        load_valid  = 1'b0;
        load_nibble = '0;
        run         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Directed program 3,4,A with the calculator presenting 7
        ovr_en  = 1'b1;
        ovr_val = 4'h7;
        load_nib(4'h3);
        load_nib(4'h4);
        load_nib(4'hA);
        run_program(1'b0);
        ovr_en = 1'b0;

        // Reset in the middle of a run
        step_q.delete();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n0 = step_q.size();
        @(negedge clk);
        rst = 1'b0;
        prog_q.delete();
        check_idle("rst_mid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_step", calc_step, 0);
        end
        chk("rst_step_total", step_q.size(), n0);

        // Nine loads into an eight-deep buffer, then replay
        for (int i = 0; i < 9; i++) load_nib(4'($urandom_range(0, 15)));
        chk("full_load_ready", load_ready, 0);
        run_program(1'b0);
        // Rerun with run/clear/load pulses while busy
        run_program(1'b1);

        // Run on an empty buffer
        do_clear();
        step_q.delete();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("empty_busy", busy, 0);
            chk("empty_step", calc_step, 0);
            @(negedge clk);
        end
        chk("empty_step_total", step_q.size(), 0);

        // run and load_valid together: load dropped
        run         = 1'b1;
        load_valid  = 1'b1;
        load_nibble = 4'h5;
        #1;
        chk("runload_ready", load_ready, 0);
        @(negedge clk);
        run        = 1'b0;
        load_valid = 1'b0;
        chk("runload_prog_len", prog_len, 0);
        chk("runload_busy", busy, 0);

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            do_clear();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) begin
                load_nib(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            run_program(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
